serial_adder: RTL and testbench

- Parametrised, bit-serial successor to the combinational half adder.
- Adds two WIDTH-bit operands and a carry-in, LSB first, one bit per clock, through a single full-adder cell and a carry flip-flop.
- Trades latency for area using a start/busy/done handshake.
- Used wherever a wide add is needed infrequently and gate count matters more than throughput.

---
 rtl/serial_adder_if.sv | 45 ++++
 rtl/serial_adder.sv | 133 +++++++++++++
 tb/tb_serial_adder.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/serial_adder_if.sv
// Request/result bundle for serial_adder. The sub signal exists only when
// SERIAL_ADDER_SUB_EN is defined.
interface serial_adder_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
`ifdef SERIAL_ADDER_SUB_EN
  logic             sub;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             carry;

  modport master (
    output start,
    output a,
    output b,
    output cin,
`ifdef SERIAL_ADDER_SUB_EN
    output sub,
`endif
    input  busy,
    input  done,
    input  sum,
    input  carry
  );

  modport slave (
    input  start,
    input  a,
    input  b,
    input  cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  sub,
`endif
    output busy,
    output done,
    output sum,
    output carry
  );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell plus a carry flop, LSB first, WIDTH cycles per add.
// Define SERIAL_ADDER_SUB_EN to add the sub input (a - b via ~b and forced carry-in).
module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input logic          clk,
  input logic          rst_n,
  serial_adder_if.slave bus
);
  localparam int unsigned CntW = $clog2(WIDTH + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  typedef enum logic [0:0] {StIdle, StShift} state_e;

  state_e state_q, state_d;

  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             c_q, c_d;
  logic             carry_q, carry_d;
  logic             done_q, done_d;

  logic             bit_s;
  logic             bit_c;
  logic             accept;
  logic             last_bit;
  logic [WIDTH-1:0] sr_shifted;
  logic [WIDTH-1:0] b_load;
  logic             c_load;

  // Full-adder cell
  assign bit_s      = sa_q[0] ^ sb_q[0] ^ c_q;
  assign bit_c      = (sa_q[0] & sb_q[0]) | (sa_q[0] & c_q) | (sb_q[0] & c_q);
  assign sr_shifted = {bit_s, sr_q[WIDTH-1:1]};

  assign accept   = (state_q == StIdle) && bus.start;
  assign last_bit = (state_q == StShift) && (cnt_q == LastCnt);

`ifdef SERIAL_ADDER_SUB_EN
  // Two's-complement subtract: invert b and force the carry-in.
  assign b_load = bus.sub ? ~bus.b : bus.b;
  assign c_load = bus.sub ? 1'b1 : bus.cin;
`else
  assign b_load = bus.b;
  assign c_load = bus.cin;
`endif

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start) state_d = StShift;
      end
      StShift: begin
        if (cnt_q == LastCnt) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs
  always_comb begin
    bus.busy  = (state_q == StShift);
    bus.done  = done_q;
    bus.sum   = sum_q;
    bus.carry = carry_q;
  end

  // Datapath next state
  always_comb begin
    sa_d    = sa_q;
    sb_d    = sb_q;
    sr_d    = sr_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    done_d  = 1'b0;
    if (accept) begin
      sa_d  = bus.a;
      sb_d  = b_load;
      c_d   = c_load;
      cnt_d = '0;
    end else if (state_q == StShift) begin
      sa_d  = sa_q >> 1;
      sb_d  = sb_q >> 1;
      sr_d  = sr_shifted;
      c_d   = bit_c;
      cnt_d = cnt_q + CntW'(1);
      if (last_bit) begin
        sum_d   = sr_shifted;
        carry_d = bit_c;
        done_d  = 1'b1;
      end
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa_q    <= '0;
      sb_q    <= '0;
      sr_q    <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      sr_q    <= sr_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      done_q  <= done_d;
    end
  end
endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: vector table, hand sequences and random ops
// against an arithmetic reference model.
module tb_serial_adder;
  localparam int unsigned W = 8;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  int   done_cnt;

  serial_adder_if #(.WIDTH(W)) bus ();

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (rst_n && bus.done) done_cnt++;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic [W-1:0] exp_sum;
    logic         exp_carry;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [W:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic cin, input logic sub);
    logic [W-1:0] nb;
    nb = ~b;
    if (sub) return {1'b0, a} + {1'b0, nb} + (W + 1)'(1);
    return {1'b0, a} + {1'b0, b} + (W + 1)'(cin);
  endfunction

  task automatic set_sub(input logic s);
`ifdef SERIAL_ADDER_SUB_EN
    bus.sub = s;
`else
    if (s) $display("note: sub request ignored in add-only build");
`endif
  endtask

  // Issue one operation; returns at the negedge where done is seen.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                       input logic sb, input logic hold, input logic at_neg,
                       output logic [W-1:0] s, output logic c, output int lat,
                       output int bcnt);
    if (!at_neg) @(negedge clk);
    bus.start = 1'b1;
    bus.a     = a;
    bus.b     = b;
    bus.cin   = cin;
    set_sub(sb);
    @(posedge clk);
    @(negedge clk);
    bcnt = bus.busy ? 1 : 0;
    lat  = 0;
    while (lat < 40) begin
      bus.start = hold;
      bus.a     = W'($urandom);
      bus.b     = W'($urandom);
      bus.cin   = 1'($urandom);
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (bus.done) break;
      if (bus.busy) bcnt++;
    end
    bus.start = 1'b0;
    if (!bus.done) check("done_timeout", 64'(bus.done), 64'd1);
    s = bus.sum;
    c = bus.carry;
  endtask

  task automatic check_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic cin, input logic sb, input logic hold, input logic at_neg);
    logic [W-1:0] s;
    logic         c;
    int           lat;
    int           bcnt;
    logic [W:0]   exp;
    exp = ref_add(a, b, cin, sb);
    do_op(a, b, cin, sb, hold, at_neg, s, c, lat, bcnt);
    check({name, "_sum"}, 64'(s), 64'(exp[W-1:0]));
    check({name, "_carry"}, 64'(c), 64'(exp[W]));
    check({name, "_latency"}, 64'(lat), 64'(W));
    check({name, "_busy_cycles"}, 64'(bcnt), 64'(W));
    check({name, "_busy_at_done"}, 64'(bus.busy), 64'd0);
  endtask

  vec_t vecs[$];

  initial begin
    logic [W-1:0] s;
    logic         c;
    int           lat;
    int           bcnt;
    int           dc0;
    logic [W-1:0] held;

    total = 0;
    bad = 0;
    done_cnt = 0;
    bus.start = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.cin = 1'b0;
    set_sub(1'b0);

    vecs.push_back('{a: 8'h00, b: 8'h00, cin: 1'b0, sub: 1'b0, exp_sum: 8'h00, exp_carry: 1'b0});
    vecs.push_back('{a: 8'hFF, b: 8'h01, cin: 1'b0, sub: 1'b0, exp_sum: 8'h00, exp_carry: 1'b1});
    vecs.push_back('{a: 8'h12, b: 8'h34, cin: 1'b0, sub: 1'b0, exp_sum: 8'h46, exp_carry: 1'b0});
    vecs.push_back('{a: 8'h7F, b: 8'h01, cin: 1'b1, sub: 1'b0, exp_sum: 8'h81, exp_carry: 1'b0});
    vecs.push_back('{a: 8'hFF, b: 8'hFF, cin: 1'b1, sub: 1'b0, exp_sum: 8'hFF, exp_carry: 1'b1});
`ifdef SERIAL_ADDER_SUB_EN
    vecs.push_back('{a: 8'h10, b: 8'h20, cin: 1'b0, sub: 1'b1, exp_sum: 8'hF0, exp_carry: 1'b0});
    vecs.push_back('{a: 8'h20, b: 8'h10, cin: 1'b0, sub: 1'b1, exp_sum: 8'h10, exp_carry: 1'b1});
    vecs.push_back('{a: 8'h20, b: 8'h10, cin: 1'b1, sub: 1'b1, exp_sum: 8'h10, exp_carry: 1'b1});
    vecs.push_back('{a: 8'h10, b: 8'h20, cin: 1'b0, sub: 1'b0, exp_sum: 8'h30, exp_carry: 1'b0});
`endif

    // Reset values
    rst_n = 1'b0;
    #12;
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_sum", 64'(bus.sum), 64'd0);
    check("rst_carry", 64'(bus.carry), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table vectors, each followed by a hold check on sum/carry
    foreach (vecs[i]) begin
      dc0 = done_cnt;
      do_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, 1'b0, 1'b0, s, c, lat, bcnt);
      check($sformatf("vec%0d_sum", i), 64'(s), 64'(vecs[i].exp_sum));
      check($sformatf("vec%0d_carry", i), 64'(c), 64'(vecs[i].exp_carry));
      check($sformatf("vec%0d_latency", i), 64'(lat), 64'(W));
      check($sformatf("vec%0d_busy_cycles", i), 64'(bcnt), 64'(W));
      held = s;
      for (int k = 0; k < 3; k++) begin
        bus.a = W'($urandom);
        bus.b = W'($urandom);
        @(negedge clk);
      end
      check($sformatf("vec%0d_sum_hold", i), 64'(bus.sum), 64'(held));
      check($sformatf("vec%0d_done_pulses", i), 64'(done_cnt - dc0), 64'd1);
    end

    // Back-to-back: second start issued in the done cycle
    check_op("b2b_first", 8'h5A, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0);
    check_op("b2b_second", 8'h12, 8'h34, 1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    check("b2b_done_single", 64'(bus.done), 64'd0);

    // start held high and operands changing throughout SHIFT
    dc0 = done_cnt;
    check_op("hold_start", 8'hC3, 8'h4E, 1'b1, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    check("hold_done_single", 64'(bus.done), 64'd0);
    @(negedge clk);
    check("hold_done_count", 64'(done_cnt - dc0), 64'd1);
    check("hold_idle_after", 64'(bus.busy), 64'd0);

    // Reset in the 4th SHIFT cycle aborts the add without a done
    @(negedge clk);
    bus.start = 1'b1;
    bus.a = 8'h80;
    bus.b = 8'h80;
    bus.cin = 1'b0;
    set_sub(1'b0);
    @(posedge clk);
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    dc0 = done_cnt;
    rst_n = 1'b0;
    #1;
    check("abort_busy", 64'(bus.busy), 64'd0);
    check("abort_sum", 64'(bus.sum), 64'd0);
    check("abort_carry", 64'(bus.carry), 64'd0);
    check("abort_done", 64'(bus.done), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (W + 4) @(negedge clk);
    check("abort_no_done", 64'(done_cnt - dc0), 64'd0);
    check_op("after_abort", 8'h80, 8'h80, 1'b0, 1'b0, 1'b0, 1'b0);

    // Random operations against the reference model
    for (int n = 0; n < 40; n++) begin
      logic sb;
`ifdef SERIAL_ADDER_SUB_EN
      sb = 1'($urandom);
`else
      sb = 1'b0;
`endif
      check_op($sformatf("rnd%0d", n), W'($urandom), W'($urandom), 1'($urandom), sb,
               1'($urandom), 1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
